// File: rtl/vlt_prog_if.sv
// Bus bundle for vlt_prog: config port, lookup lanes, lookup results,
// accumulator outputs and init status.
//   master : driver side (config writer / dispatch lanes / estimator)
//   slave  : vlt_prog side
// Optional parity signals exist only when VLT_PARITY_EN is defined:
//   cfg_par_inj (in), out_perr (out, per lane), perr_sticky (out).
interface vlt_prog_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned VBIT_W     = 8,
  parameter int unsigned ACC_W      = 32
);
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned FIELD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  logic                                cfg_we;
  logic [IDX_W-1:0]                    cfg_addr;
  logic [FIELD_W-1:0]                  cfg_field;
  logic [VBIT_W-1:0]                   cfg_wdata;
  logic [VBIT_W-1:0]                   cfg_rdata;
  logic [NUM_CH-1:0]                   lu_valid;
  logic [NUM_CH*2-1:0]                 lu_class;
  logic [NUM_CH*4-1:0]                 lu_vop;
  logic [NUM_CH-1:0]                   lu_important;
  logic [NUM_CH-1:0]                   out_valid;
  logic [NUM_CH*NUM_FIELDS*VBIT_W-1:0] out_vbit;
  logic                                acc_clear;
  logic [NUM_FIELDS*ACC_W-1:0]         acc_sum;
  logic [NUM_FIELDS-1:0]               acc_sat;
  logic                                init_busy;
`ifdef VLT_PARITY_EN
  logic                                cfg_par_inj;
  logic [NUM_CH-1:0]                   out_perr;
  logic                                perr_sticky;
`endif

  modport master (
    output cfg_we, cfg_addr, cfg_field, cfg_wdata,
    output lu_valid, lu_class, lu_vop, lu_important, acc_clear,
`ifdef VLT_PARITY_EN
    output cfg_par_inj,
    input  out_perr, perr_sticky,
`endif
    input  cfg_rdata, out_valid, out_vbit, acc_sum, acc_sat, init_busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_field, cfg_wdata,
    input  lu_valid, lu_class, lu_vop, lu_important, acc_clear,
`ifdef VLT_PARITY_EN
    input  cfg_par_inj,
    output out_perr, perr_sticky,
`endif
    output cfg_rdata, out_valid, out_vbit, acc_sum, acc_sat, init_busy
  );
endinterface

// File: rtl/vlt_prog.sv
// vlt_prog: runtime-programmable vulnerable-bit lookup tables with
// per-field saturating accumulation across lanes.
//
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset (restarts table initialisation)
//   bus      vlt_prog_if.slave
//     cfg_we/cfg_addr/cfg_field/cfg_wdata  single-field table write
//     cfg_rdata                            registered readback (1 cycle)
//     lu_valid/lu_class/lu_vop/lu_important per-lane lookup request
//     out_valid/out_vbit                   registered lookup results
//     acc_clear                            synchronous accumulator clear
//     acc_sum/acc_sat                      per-field sums, sticky sat flags
//     init_busy                            table initialisation running
//
// Optional feature (macro VLT_PARITY_EN): per-field even parity, error
// injection through cfg_par_inj, per-lane out_perr and a sticky perr_sticky.
module vlt_prog #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned VBIT_W     = 8,
  parameter int unsigned ACC_W      = 32,
  parameter logic [NUM_FIELDS*VBIT_W-1:0] DEF_VBIT = {8'd21, 8'd5, 8'd16, 8'd23}
) (
  input logic       clk,
  input logic       reset_n,
  vlt_prog_if.slave bus
);
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned LANE_W = NUM_FIELDS * VBIT_W;
  // Widest per-cycle contribution of one field across all lanes.
  localparam int unsigned ADD_W  = VBIT_W + $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W  = ((ACC_W > ADD_W) ? ACC_W : ADD_W) + 1;

  typedef enum logic {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic             running;

  logic [VBIT_W-1:0] mem_q [DEPTH][NUM_FIELDS];

  logic [IDX_W-1:0] lu_idx [NUM_CH];

  logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
  logic [NUM_CH*LANE_W-1:0] out_vbit_q, out_vbit_d;
  logic [VBIT_W-1:0]        cfg_rdata_q, cfg_rdata_d;

  logic [NUM_FIELDS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_FIELDS-1:0]            sat_q, sat_d;
  logic [ADD_W-1:0]                 lane_sum [NUM_FIELDS];
  logic [SUM_W-1:0]                 acc_ext  [NUM_FIELDS];

  // ---------------------------------------------------------------------------
  // Init / run FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      StInit: begin
        init_ptr_d = init_ptr_q + IDX_W'(1);
        if (init_ptr_q == IDX_W'(DEPTH - 1)) state_d = StRun;
      end
      StRun: begin
      end
    endcase
  end

  assign running = (state_q == StRun);

  // ---------------------------------------------------------------------------
  // Table storage (no reset: contents are rebuilt by INIT)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!running) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        mem_q[init_ptr_q][f] <= DEF_VBIT[f*VBIT_W +: VBIT_W];
      end
    end else if (bus.cfg_we) begin
      mem_q[bus.cfg_addr][bus.cfg_field] <= bus.cfg_wdata;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lu_idx[c] = {bus.lu_class[2*c +: 2], bus.lu_vop[4*c +: 4], bus.lu_important[c]};
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup and readback; reads see the table before this edge's write
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = '0;
    out_vbit_d  = out_vbit_q;
    cfg_rdata_d = '0;
    if (running) begin
      out_valid_d = bus.lu_valid;
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.lu_valid[c]) begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            out_vbit_d[c*LANE_W + f*VBIT_W +: VBIT_W] = mem_q[lu_idx[c]][f];
          end
        end
      end
      cfg_rdata_d = mem_q[bus.cfg_addr][bus.cfg_field];
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulation of the registered lookup results
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      lane_sum[f] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (out_valid_q[c]) begin
          lane_sum[f] = lane_sum[f] + ADD_W'(out_vbit_q[c*LANE_W + f*VBIT_W +: VBIT_W]);
        end
      end
      acc_ext[f] = SUM_W'(acc_q[f]) + SUM_W'(lane_sum[f]);
      if (bus.acc_clear) begin
        acc_d[f] = '0;
        sat_d[f] = 1'b0;
      end else if (sat_q[f] || (|(acc_ext[f] >> ACC_W))) begin
        acc_d[f] = '1;
        sat_d[f] = 1'b1;
      end else begin
        acc_d[f] = acc_ext[f][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      init_ptr_q  <= '0;
      out_valid_q <= '0;
      out_vbit_q  <= '0;
      cfg_rdata_q <= '0;
      acc_q       <= '0;
      sat_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      out_valid_q <= out_valid_d;
      out_vbit_q  <= out_vbit_d;
      cfg_rdata_q <= cfg_rdata_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vbit  = out_vbit_q;
  assign bus.cfg_rdata = cfg_rdata_q;
  assign bus.acc_sum   = acc_q;
  assign bus.acc_sat   = sat_q;
  assign bus.init_busy = !running;

`ifdef VLT_PARITY_EN
  // ---------------------------------------------------------------------------
  // Even parity per stored field; cfg_par_inj flips the stored bit
  // ---------------------------------------------------------------------------
  logic [NUM_FIELDS-1:0] par_q [DEPTH];
  logic [NUM_CH-1:0]     perr_d, perr_q;
  logic                  perr_sticky_q;

  always_ff @(posedge clk) begin
    if (!running) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        par_q[init_ptr_q][f] <= ^DEF_VBIT[f*VBIT_W +: VBIT_W];
      end
    end else if (bus.cfg_we) begin
      par_q[bus.cfg_addr][bus.cfg_field] <= (^bus.cfg_wdata) ^ bus.cfg_par_inj;
    end
  end

  always_comb begin
    perr_d = '0;
    if (running) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.lu_valid[c]) begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            if (par_q[lu_idx[c]][f] != (^mem_q[lu_idx[c]][f])) perr_d[c] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q        <= '0;
      perr_sticky_q <= 1'b0;
    end else begin
      perr_q        <= perr_d;
      perr_sticky_q <= bus.acc_clear ? 1'b0 : (perr_sticky_q | (|perr_d));
    end
  end

  assign bus.out_perr    = perr_q;
  assign bus.perr_sticky = perr_sticky_q;
`endif
endmodule
